// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and the pipeline stages around it:
// default geometry plus the data-word and register-address types.
package reg_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int DEFAULT_NUM_REGS   = 2 ** DEFAULT_ADDR_WIDTH;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Read/write port bundle of the register file: the execute/writeback side drives
// through the master modport, the register file responds through the slave modport.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd1_data;
    logic [ADDR_WIDTH-1:0] wr1;
    logic [DATA_WIDTH-1:0] wr1_data;
    logic                  wr1_enable;

    modport master (
        output rd1,
        output wr1,
        output wr1_data,
        output wr1_enable,
        input  rd1_data
    );

    modport slave (
        input  rd1,
        input  wr1,
        input  wr1_data,
        input  wr1_enable,
        output rd1_data
    );

endinterface

// File: rtl/reg_file_cell.sv
// One storage word of the register file: synchronous active-high clear with
// priority over the load enable.
module reg_file_cell
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] q_out
);

    logic [DATA_WIDTH-1:0] value_d;
    logic [DATA_WIDTH-1:0] value_q;

    always_comb begin
        value_d = load ? d_in : value_q;
    end

    // NOTE: non-blocking assignment so every cell updates from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign q_out = value_q;

endmodule

// File: rtl/reg_file.sv
// Register file with one combinational read port and one synchronous write port.
// Writes are decoded to a one-hot load vector; reads have no write bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
    input  logic        clock,
    input  logic        reset,
    reg_file_if.slave   bus
);

    logic [NUM_REGS-1:0]   load_vec;
    logic [DATA_WIDTH-1:0] cell_q [NUM_REGS];

    // NOTE: default first so the decode cannot infer a latch for unaddressed bits.
    always_comb begin
        load_vec          = '0;
        load_vec[bus.wr1] = bus.wr1_enable;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        reg_file_cell #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .clock (clock),
            .reset (reset),
            .load  (load_vec[i]),
            .d_in  (bus.wr1_data),
            .q_out (cell_q[i])
        );
    end

    assign bus.rd1_data = cell_q[bus.rd1];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected read values into a
// scoreboard queue, a separate monitor pops and compares against rd1_data.
module tb_reg_file;
    import reg_file_pkg::*;

    typedef struct {
        string name;
        data_t exp;
    } exp_t;

    logic  clock = 1'b0;
    logic  reset;
    exp_t  exp_q[$];
    event  sample_ev;
    int    total_checks = 0;
    int    passed_checks = 0;

    reg_file_if bus ();

    reg_file dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clock = ~clock;

    // Present a read address, let it settle, then hand the expectation to the monitor.
    task automatic check_read(input addr_t addr, input data_t exp, input string name);
        exp_t e;
        bus.rd1 = addr;
        #1;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic write_word(input addr_t addr, input data_t data);
        bus.wr1        = addr;
        bus.wr1_data   = data;
        bus.wr1_enable = 1'b1;
        @(negedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total_checks++;
                if (bus.rd1_data !== e.exp) begin
                    $display("FAIL %s: rd1=%0d got 0x%04h expected 0x%04h",
                             e.name, bus.rd1, bus.rd1_data, e.exp);
                end else begin
                    passed_checks++;
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed",
                 passed_checks, total_checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset          = 1'b1;
        bus.rd1        = '0;
        bus.wr1        = '0;
        bus.wr1_data   = '0;
        bus.wr1_enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            check_read(addr_t'(i), 16'h0000, "reset_clear");
        end

        write_word(2'd0, 16'h0010);
        write_word(2'd1, 16'h0020);
        write_word(2'd2, 16'hABCD);
        bus.wr1_enable = 1'b0;
        check_read(2'd1, 16'h0020, "write_r1");
        check_read(2'd2, 16'hABCD, "write_r2");
        check_read(2'd0, 16'h0010, "write_r0");
        check_read(2'd3, 16'h0000, "untouched_r3");

        bus.wr1        = 2'd1;
        bus.wr1_data   = 16'hFFFF;
        bus.wr1_enable = 1'b0;
        @(negedge clock);
        check_read(2'd1, 16'h0020, "write_disabled");

        bus.wr1        = 2'd3;
        bus.wr1_data   = 16'h1234;
        bus.wr1_enable = 1'b1;
        check_read(2'd3, 16'h0000, "collision_before_edge");
        @(negedge clock);
        bus.wr1_enable = 1'b0;
        check_read(2'd3, 16'h1234, "collision_after_edge");
        check_read(2'd0, 16'h0010, "others_hold_r0");
        check_read(2'd1, 16'h0020, "others_hold_r1");
        check_read(2'd2, 16'hABCD, "others_hold_r2");

        reset          = 1'b1;
        bus.wr1        = 2'd0;
        bus.wr1_data   = 16'h5555;
        bus.wr1_enable = 1'b1;
        @(negedge clock);
        reset          = 1'b0;
        bus.wr1_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_read(addr_t'(i), 16'h0000, "reset_beats_write");
        end

        write_word(2'd2, 16'h0BEE);
        write_word(2'd1, 16'h7777);
        bus.wr1_enable = 1'b0;
        check_read(2'd2, 16'h0BEE, "read_follows_a");
        check_read(2'd1, 16'h7777, "read_follows_b");
        check_read(2'd2, 16'h0BEE, "read_follows_c");

        #1;
        if (exp_q.size() != 0) begin
            total_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
